key_scheduler: RTL
==================

KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 SHALL have parameter DAS_CYCLES, default 16, delay from press to first auto-repeat of a movement key.
REQ-002 SHALL have parameter ARR_CYCLES, default 4, interval between auto-repeat requests.
REQ-003 SHALL have parameter GAP_CYCLES, default 8, cooldown cycles after each issued pulse.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 btn_left, btn_right, btn_down  in  1 each  debounced held levels, movement keys.
REQ-008 btn_rot_cw, btn_rot_ccw, btn_drop, btn_hold  in  1 each  debounced held levels, single-shot keys.
REQ-009 core_ready  in  1  game core is idle and accepting a key pulse.
REQ-010 game_over  in  1  game core halted.
REQ-011 key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw, key_drop, key_hold  out  1 each  one-cycle command pulses to game core.
REQ-012 key_drop_held  out  1  registered copy of btn_drop, forced 0 while game_over=1.
REQ-013 busy  out  1  high in ISSUE or COOLDOWN.

Function
REQ-014 Rising edge of any button SHALL set its pending bit; pending bits saturate (repeats of a pending request are dropped, not counted).
REQ-015 Single-shot pending bits SHALL persist after button release until issued (tap never lost).
REQ-016 Movement keys: held continuously for DAS_CYCLES after the edge -> set pending; thereafter every ARR_CYCLES while held; release resets that key's counter to 0.
REQ-017 left/right share one horizontal counter; down has its own counter.
REQ-018 btn_left and btn_right both high: neither sets pending, horizontal counter held at 0; pending bits already set remain.
REQ-019 Left and right rising in same cycle: neither pending set.
REQ-020 FSM states IDLE, ISSUE, COOLDOWN.
REQ-021 IDLE -> ISSUE when any pending bit set and core_ready=1 and game_over=0.
REQ-022 ISSUE (one cycle): assert exactly one output pulse, highest priority pending: hold > drop > rotate_cw > rotate_ccw > left > right > down; clear that pending bit; -> COOLDOWN.
REQ-023 COOLDOWN: count GAP_CYCLES cycles, then -> IDLE; pending bits continue to accumulate.
REQ-024 Issue latency: pending set at cycle N with core_ready=1 in IDLE -> pulse at cycle N+1 (registered outputs).
REQ-025 At most one output pulse high in any cycle; pulses never wider than one cycle.
REQ-026 Issuing drop SHALL also clear pending left/right/down/rotate bits (stale moves discarded across piece lock).
REQ-027 game_over=1: clear all pending bits and counters each cycle, force FSM to IDLE, no pulses; edges during game_over not remembered.
REQ-028 Counters saturate; no wrap for DAS_CYCLES, ARR_CYCLES up to 2^16-1.
REQ-029 core_ready low in IDLE: hold state, no pulse; no timeout.

Reset
REQ-030 rst_n low SHALL asynchronously clear all outputs to 0, all pending bits, edge-detect registers (to 0, so a button held through reset yields an edge on release of reset), counters to 0, FSM to IDLE.
REQ-031 Reset mid-ISSUE SHALL suppress the pulse in that cycle.

Structure
REQ-032 Key-index enum (priority order) and FSM state enum SHALL reside in the shared package alongside existing game typedefs.
REQ-033 One sub-module key_repeat (edge detect + DAS/ARR counter for one key, parameterised) SHALL be instantiated for left/right pair and down.

Verification (DAS=16, ARR=4, GAP=8)
REQ-034 Hold btn_left 40 cycles, core_ready=1 -> key_left pulses at cycles 1, ~17, then every max(ARR, GAP+2) cycles; no other key pulses.
REQ-035 btn_hold, btn_drop, btn_left rise same cycle -> order key_hold, key_drop; key_left discarded by REQ-026; exactly two pulses.
REQ-036 Tap btn_rot_cw 1 cycle with core_ready=0 for 50 cycles, then core_ready=1 -> single key_rotate_cw one cycle later.
REQ-037 Both btn_left and btn_right held 60 cycles -> zero horizontal pulses.
REQ-038 Pending btn_down, then game_over=1 for 5 cycles, then 0 -> no key_down ever; key_drop_held 0 throughout game_over.
REQ-039 rst_n low for 1 cycle during COOLDOWN -> all outputs 0 immediately, FSM IDLE, next press issues with latency 1.

Source files
------------

// File: rtl/key_scheduler_pkg.sv
// rtl/key_scheduler_pkg.sv - shared game typedefs, key priority order and scheduler states
package key_scheduler_pkg;

  typedef enum logic [2:0] {
    PIECE_I, PIECE_O, PIECE_T, PIECE_S, PIECE_Z, PIECE_J, PIECE_L
  } piece_t;

  localparam int NUM_KEYS = 7;
  localparam int CNT_W    = 16;

  // Enum order is issue priority: lowest index wins.
  typedef enum logic [2:0] {
    KEY_HOLD    = 3'd0,
    KEY_DROP    = 3'd1,
    KEY_ROT_CW  = 3'd2,
    KEY_ROT_CCW = 3'd3,
    KEY_LEFT    = 3'd4,
    KEY_RIGHT   = 3'd5,
    KEY_DOWN    = 3'd6
  } key_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_COOLDOWN
  } sched_state_t;

  // A drop locks the piece, so only a pending hold survives it.
  localparam logic [NUM_KEYS-1:0] KEEP_ON_DROP = 7'b000_0001;

  function automatic logic [NUM_KEYS-1:0] prio_pick(input logic [NUM_KEYS-1:0] pend);
    prio_pick = pend & (-pend);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - edge detect plus DAS/ARR auto-repeat for a group of mutually exclusive keys
module key_repeat
  import key_scheduler_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int DAS_CYCLES = 16,
  parameter int ARR_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_fire
);

  localparam logic [CNT_W-1:0] DAS_W = CNT_W'(DAS_CYCLES);
  localparam logic [CNT_W-1:0] ARR_W = CNT_W'(ARR_CYCLES);

  logic [WIDTH-1:0] r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rep;

  logic [WIDTH-1:0] w_edge;
  logic [CNT_W-1:0] w_cnt;
  logic             w_edge_any;
  logic             w_active;
  logic             w_rep;
  logic             w_tick;

  assign w_edge = i_btn & ~r_prev;
  // The group counts only while exactly one of its keys is down.
  assign w_active = $onehot(i_btn);

  always_comb begin
    w_edge_any = |w_edge;
    w_cnt      = w_edge_any ? '0 : r_cnt;
    w_rep      = w_edge_any ? 1'b0 : r_rep;
    w_tick     = w_rep ? (w_cnt == ARR_W) : (w_cnt == DAS_W);
    o_fire     = '0;
    if (w_active && !i_clear) begin
      o_fire = i_btn & (w_edge | {WIDTH{w_tick}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_cnt  <= '0;
      r_rep  <= 1'b0;
    end else begin
      r_prev <= i_btn;
      if (i_clear || !w_active) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_tick) begin
        r_cnt <= CNT_W'(1);
        r_rep <= 1'b1;
      end else begin
        r_rep <= w_rep;
        r_cnt <= (w_cnt == '1) ? w_cnt : w_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_scheduler.sv
// rtl/key_scheduler.sv - turns held button levels into prioritised, rate-limited key pulses
module key_scheduler
  import key_scheduler_pkg::*;
#(
  parameter int DAS_CYCLES = 16,
  parameter int ARR_CYCLES = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_rot_cw,
  input  logic btn_rot_ccw,
  input  logic btn_drop,
  input  logic btn_hold,
  input  logic core_ready,
  input  logic game_over,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate_cw,
  output logic key_rotate_ccw,
  output logic key_drop,
  output logic key_hold,
  output logic key_drop_held,
  output logic busy
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  sched_state_t        r_state, w_state_nxt;
  logic [3:0]          r_prev_ss;
  logic [NUM_KEYS-1:0] r_pend, w_pend_nxt;
  logic [NUM_KEYS-1:0] r_pulse, w_pulse_nxt;
  logic [CNT_W-1:0]    r_gap, w_gap_nxt;
  logic                r_drop_held;

  logic [3:0]          w_ss_btn;
  logic [3:0]          w_ss_edge;
  logic [1:0]          w_fire_h;
  logic                w_fire_d;
  logic [NUM_KEYS-1:0] w_set;
  logic [NUM_KEYS-1:0] w_pick;

  assign w_ss_btn  = {btn_rot_ccw, btn_rot_cw, btn_drop, btn_hold};
  assign w_ss_edge = w_ss_btn & ~r_prev_ss & {4{~game_over}};

  key_repeat #(
    .WIDTH     (2),
    .DAS_CYCLES(DAS_CYCLES),
    .ARR_CYCLES(ARR_CYCLES)
  ) u_rep_horiz (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(game_over),
    .i_btn  ({btn_right, btn_left}),
    .o_fire (w_fire_h)
  );

  key_repeat #(
    .WIDTH     (1),
    .DAS_CYCLES(DAS_CYCLES),
    .ARR_CYCLES(ARR_CYCLES)
  ) u_rep_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(game_over),
    .i_btn  (btn_down),
    .o_fire (w_fire_d)
  );

  assign w_set = {w_fire_d, w_fire_h[1], w_fire_h[0], w_ss_edge};

  // Requests raised this cycle are visible to IDLE immediately, giving one-cycle issue latency.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend | w_set;
    w_pulse_nxt = '0;
    w_gap_nxt   = r_gap;
    w_pick      = prio_pick(r_pend | w_set);
    if (game_over) begin
      w_state_nxt = ST_IDLE;
      w_pend_nxt  = '0;
      w_gap_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((|w_pend_nxt) && core_ready) begin
            w_state_nxt = ST_ISSUE;
            w_pulse_nxt = w_pick;
            w_pend_nxt  = w_pend_nxt & ~w_pick;
            if (w_pick[KEY_DROP]) begin
              w_pend_nxt = w_pend_nxt & KEEP_ON_DROP;
            end
          end
        end
        ST_ISSUE: begin
          w_state_nxt = ST_COOLDOWN;
          w_gap_nxt   = '0;
        end
        ST_COOLDOWN: begin
          if (r_gap >= GAP_LAST) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_gap_nxt = r_gap + CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prev_ss   <= '0;
      r_pend      <= '0;
      r_pulse     <= '0;
      r_gap       <= '0;
      r_drop_held <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_ss   <= w_ss_btn;
      r_pend      <= w_pend_nxt;
      r_pulse     <= w_pulse_nxt;
      r_gap       <= w_gap_nxt;
      r_drop_held <= btn_drop & ~game_over;
    end
  end

  assign key_hold       = r_pulse[KEY_HOLD]    & ~game_over;
  assign key_drop       = r_pulse[KEY_DROP]    & ~game_over;
  assign key_rotate_cw  = r_pulse[KEY_ROT_CW]  & ~game_over;
  assign key_rotate_ccw = r_pulse[KEY_ROT_CCW] & ~game_over;
  assign key_left       = r_pulse[KEY_LEFT]    & ~game_over;
  assign key_right      = r_pulse[KEY_RIGHT]   & ~game_over;
  assign key_down       = r_pulse[KEY_DOWN]    & ~game_over;
  assign key_drop_held  = r_drop_held & ~game_over;
  assign busy           = (r_state != ST_IDLE);

endmodule
